// File: rtl/hdmi_fb_arbiter_if.sv
// hdmi_fb_arbiter_if: scanout, writer, RAM and stats signals of the framebuffer arbiter
interface hdmi_fb_arbiter_if #(parameter int ADDR_W = 19);
  logic              frame_start_i;
  logic              pix_req_i;
  logic [23:0]       pixel_o;
  logic              pix_valid_o;
  logic              underflow_o;
  logic              wr_valid_i;
  logic [ADDR_W-1:0] wr_addr_i;
  logic [23:0]       wr_data_i;
  logic              wr_ready_o;
  logic              mem_en_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [23:0]       mem_wdata_o;
  logic [23:0]       mem_rdata_i;
  logic [15:0]       stat_underflow_o;
  logic [15:0]       stat_wr_stall_o;
  modport slave (
    input  frame_start_i, pix_req_i, wr_valid_i, wr_addr_i, wr_data_i, mem_rdata_i,
    output pixel_o, pix_valid_o, underflow_o, wr_ready_o, mem_en_o, mem_we_o,
           mem_addr_o, mem_wdata_o, stat_underflow_o, stat_wr_stall_o
  );
  modport master (
    output frame_start_i, pix_req_i, wr_valid_i, wr_addr_i, wr_data_i, mem_rdata_i,
    input  pixel_o, pix_valid_o, underflow_o, wr_ready_o, mem_en_o, mem_we_o,
           mem_addr_o, mem_wdata_o, stat_underflow_o, stat_wr_stall_o
  );
endinterface

// File: rtl/hdmi_fb_arbiter.sv
// hdmi_fb_arbiter: single-port framebuffer sharing between scanout prefetch and trace writer; FB_ARB_STATS_EN builds stat counters
module hdmi_fb_arbiter #(
  parameter int ADDR_W      = 19,
  parameter int FB_PIXELS   = 307200,
  parameter int FIFO_DEPTH  = 16,
  parameter int REFILL_LVL  = 8,
  parameter int WR_MAX_WAIT = 32
) (
  input logic              pixclk_i,
  input logic              rst_i,
  hdmi_fb_arbiter_if.slave bus
);
  localparam int FA = $clog2(FIFO_DEPTH);
  localparam int WW = $clog2(WR_MAX_WAIT + 1);
  localparam logic [0:0] S_FLUSH = 1'b0;
  localparam logic [0:0] S_RUN   = 1'b1;
  localparam logic [FA+1:0] P_REFILL = (FA+2)'(REFILL_LVL);
  localparam logic [FA+1:0] P_DEPTH  = (FA+2)'(FIFO_DEPTH);
  localparam logic [WW-1:0] P_MAXW   = WW'(WR_MAX_WAIT);
  localparam logic [ADDR_W-1:0] P_LAST = ADDR_W'(FB_PIXELS - 1);

  logic [0:0]        r_state;
  logic              r_inflight;
  logic              r_underflow;
  logic [FA:0]       r_level;
  logic [FA-1:0]     r_wptr;
  logic [FA-1:0]     r_rptr;
  logic [WW-1:0]     r_wait;
  logic [ADDR_W-1:0] r_rd_addr;
  logic [23:0]       r_fifo [FIFO_DEPTH];

  logic [FA+1:0] w_occ;
  logic          w_run;
  logic          w_urgent;
  logic          w_ready;
  logic          w_wr;
  logic          w_rd;
  logic          w_push;
  logic          w_pop;
  logic          w_valid;

  // arbitration looks only at registered state so wr_ready_o never depends on wr_valid_i
  assign w_occ    = {1'b0, r_level} + (FA+2)'(r_inflight);
  assign w_run    = r_state == S_RUN;
  assign w_urgent = w_run && w_occ < P_REFILL && r_wait < P_MAXW;
  assign w_ready  = !rst_i && !w_urgent;
  assign w_wr     = bus.wr_valid_i && w_ready;
  assign w_rd     = !rst_i && w_run && !w_wr && w_occ < P_DEPTH;
  assign w_valid  = r_level != '0;
  assign w_push   = r_inflight && w_run && !bus.frame_start_i;
  assign w_pop    = bus.pix_req_i && w_valid && !bus.frame_start_i;

  assign bus.wr_ready_o  = w_ready;
  assign bus.mem_en_o    = w_wr || w_rd;
  assign bus.mem_we_o    = w_wr;
  assign bus.mem_addr_o  = w_wr ? bus.wr_addr_i : w_rd ? r_rd_addr : '0;
  assign bus.mem_wdata_o = w_wr ? bus.wr_data_i : '0;
  assign bus.pix_valid_o = w_valid;
  assign bus.pixel_o     = w_valid ? r_fifo[r_rptr] : '0;
  assign bus.underflow_o = r_underflow;

  always_ff @(posedge pixclk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= S_FLUSH;
      r_inflight  <= 1'b0;
      r_underflow <= 1'b0;
      r_level     <= '0;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_wait      <= '0;
      r_rd_addr   <= '0;
    end else begin
      r_state     <= bus.frame_start_i ? S_FLUSH : S_RUN;
      r_inflight  <= w_rd;
      r_underflow <= bus.pix_req_i && !w_valid && !bus.frame_start_i;
      if (bus.frame_start_i) begin
        r_rd_addr <= '0;
        r_level   <= '0;
        r_wptr    <= '0;
        r_rptr    <= '0;
      end else begin
        if (w_rd) r_rd_addr <= r_rd_addr == P_LAST ? '0 : r_rd_addr + ADDR_W'(1);
        if (w_push) r_wptr <= r_wptr + FA'(1);
        if (w_pop) r_rptr <= r_rptr + FA'(1);
        r_level <= r_level + (FA+1)'(w_push) - (FA+1)'(w_pop);
      end
      if (!bus.wr_valid_i || w_ready) r_wait <= '0;
      else if (r_wait != '1) r_wait <= r_wait + WW'(1);
    end
  end

  always_ff @(posedge pixclk_i) begin
    if (w_push) r_fifo[r_wptr] <= bus.mem_rdata_i;
  end

`ifdef FB_ARB_STATS_EN
  logic [15:0] r_stat_uf;
  logic [15:0] r_stat_st;
  always_ff @(posedge pixclk_i or posedge rst_i) begin
    if (rst_i) begin
      r_stat_uf <= '0;
      r_stat_st <= '0;
    end else begin
      if (r_underflow && r_stat_uf != 16'hFFFF) r_stat_uf <= r_stat_uf + 16'd1;
      if (bus.wr_valid_i && !w_ready && r_stat_st != 16'hFFFF) r_stat_st <= r_stat_st + 16'd1;
    end
  end
  assign bus.stat_underflow_o = r_stat_uf;
  assign bus.stat_wr_stall_o  = r_stat_st;
`else
  assign bus.stat_underflow_o = '0;
  assign bus.stat_wr_stall_o  = '0;
`endif
endmodule
